// File: rtl/exe_mem_reg.sv
// exe_mem_reg: EXE->MEM pipeline register (clk/rst, EXE_* in, MEM_Stall/Flush ctl, MEM_* out, EXE_Stall, MEM_LoadHazard, BubbleCnt)
package exe_mem_pkg;
  typedef struct packed {
    logic RFWr;
    logic HIWr;
    logic LOWr;
    logic CP0Wr;
  } RegsWrType;
endpackage

module exe_mem_reg
  import exe_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_Valid,
  input  logic        EXE_Busy,
  input  logic [31:0] EXE_Result,
  input  logic [4:0]  EXE_Dst,
  input  RegsWrType   EXE_RegsWrType,
  input  logic        EXE_MemToReg,
  input  logic [31:0] EXE_PC,
  input  logic        MEM_Stall,
  input  logic        Flush,
  output logic        EXE_Stall,
  output logic        MEM_Valid,
  output logic [31:0] MEM_Result,
  output logic [4:0]  MEM_Dst,
  output RegsWrType   MEM_RegsWrType,
  output logic        MEM_MemToReg,
  output logic [31:0] MEM_PC,
  output logic        MEM_LoadHazard,
  output logic [15:0] BubbleCnt
);
  logic bubble;
  assign bubble = EXE_Busy | !EXE_Valid;
  assign EXE_Stall = (MEM_Stall | EXE_Busy) & !Flush;
  assign MEM_LoadHazard = MEM_Valid & MEM_MemToReg & MEM_RegsWrType.RFWr & (MEM_Dst != 5'd0);
  always_ff @(posedge clk) begin
    if (rst | Flush) begin
      MEM_Valid      <= 1'b0;
      MEM_Result     <= '0;
      MEM_Dst        <= '0;
      MEM_RegsWrType <= '0;
      MEM_MemToReg   <= 1'b0;
      MEM_PC         <= '0;
      BubbleCnt      <= rst ? 16'd0 : BubbleCnt;
    end else if (!MEM_Stall) begin
      MEM_Valid      <= !bubble;
      MEM_Result     <= bubble ? '0 : EXE_Result;
      MEM_Dst        <= bubble ? '0 : EXE_Dst;
      MEM_RegsWrType <= bubble ? '0 : EXE_RegsWrType;
      MEM_MemToReg   <= bubble ? 1'b0 : EXE_MemToReg;
      MEM_PC         <= bubble ? '0 : EXE_PC;
      BubbleCnt      <= BubbleCnt + {15'd0, bubble};
    end
  end
endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 EXE_Valid  in  1  EXE slot holds a real instruction.
REQ-004 EXE_Busy  in  1  EXE multi-cycle op (mul/div) not finished; result not yet valid.
REQ-005 EXE_Result  in  32  EXE ALU/forwarded result.
REQ-006 EXE_Dst  in  5  destination GPR index.
REQ-007 EXE_RegsWrType  in  RegsWrType  write-type struct (RFWr and the other write-enable fields).
REQ-008 EXE_MemToReg  in  1  instruction is a load.
REQ-009 EXE_PC  in  32  instruction PC.
REQ-010 MEM_Stall  in  1  MEM cannot accept; hold register.
REQ-011 Flush  in  1  exception/ERET flush of this slot.
REQ-012 EXE_Stall  out  1  back-pressure to EXE/ID/IF.
REQ-013 MEM_Valid, MEM_Result(32), MEM_Dst(5), MEM_RegsWrType, MEM_MemToReg, MEM_PC(32)  out  registered copies feeding MEM and the EXE forwarding unit.
REQ-014 MEM_LoadHazard  out  1  combinational: MEM_Valid & MEM_MemToReg & MEM_RegsWrType.RFWr & MEM_Dst!=0.
REQ-015 BubbleCnt  out  16  count of bubbles inserted since reset.

Function
REQ-016 Per-cycle priority SHALL be: rst > Flush > MEM_Stall (hold) > bubble (EXE_Busy | !EXE_Valid) > capture.
REQ-017 Capture: all MEM_* outputs SHALL take the EXE_* values at the clock edge; MEM_Valid=1; latency exactly 1 cycle.
REQ-018 Bubble: MEM_Valid=0, MEM_Dst=0, every MEM_RegsWrType field=0, MEM_MemToReg=0, MEM_Result=0, MEM_PC=0.
REQ-019 Hold: every MEM_* output SHALL keep its previous value; BubbleCnt unchanged.
REQ-020 Flush: same register values as bubble, including during MEM_Stall; BubbleCnt unchanged.
REQ-021 BubbleCnt SHALL increment by 1 only on a bubble cycle (not rst, Flush or hold), wrapping 0xFFFF->0x0000.
REQ-022 EXE_Stall = (MEM_Stall | EXE_Busy) & !Flush, combinational.
REQ-023 A bubble SHALL never leave MEM_RegsWrType.RFWr=1, so forwarding never selects an invalid result.
REQ-024 MEM_Dst=0 with RFWr=1 SHALL be captured unchanged; consumers mask r0 themselves.
REQ-025 EXE_Busy falling on the same edge as MEM_Stall rising: hold wins; the result is captured on the first non-stalled edge, provided EXE still presents it.

Reset
REQ-026 When rst is high at an edge, all MEM_* outputs and BubbleCnt SHALL be 0 at the next edge, whatever the other inputs.
REQ-027 After rst, MEM_LoadHazard=0 and EXE_Stall follows REQ-022 combinationally.
REQ-028 rst asserted mid-stall or mid-busy SHALL discard the held instruction; there is no replay.

Verification
REQ-029 Capture: EXE_Valid=1, Result=0xDEADBEEF, Dst=8, RFWr=1, PC=0xBFC00010 -> next cycle MEM_* equal these values and MEM_Valid=1.
REQ-030 Hold: capture as in REQ-029, then MEM_Stall=1 for 3 cycles with new EXE inputs -> MEM_* unchanged for 3 cycles and EXE_Stall=1.
REQ-031 Flush over stall: MEM_Stall=1 and Flush=1 together -> next cycle MEM_Valid=0, RFWr=0, Dst=0, BubbleCnt unchanged, EXE_Stall=0.
REQ-032 Busy: EXE_Busy=1 for 5 cycles, then 0 with a valid op -> 5 bubbles, BubbleCnt=5, then capture; EXE_Stall=1 during busy.
REQ-033 Load hazard: capture a load (MemToReg=1, RFWr=1, Dst=3) -> MEM_LoadHazard=1; the same load with Dst=0 -> MEM_LoadHazard=0.
REQ-034 Wrap and reset: preload BubbleCnt to 0xFFFF, one bubble -> 0x0000; rst during a hold -> all outputs 0 next cycle.
